// File: rtl/cmdout_subqueue_writer.sv
// Writes multi-beat cmdout commands into per-accelerator circular subqueues
// in the shared cmdout BRAM, publishing each command by writing its header last.
module cmdout_subqueue_writer #(
    parameter int MAX_ACCS     = 16,
    parameter int SUBQUEUE_LEN = 64,
    parameter int VALID_BIT    = 63,
    parameter int RETRY_WAIT   = 4
) (
    input  logic                        aclk,
    input  logic                        interconnect_aresetn,
    input  logic                        cmdout_in_tvalid,
    output logic                        cmdout_in_tready,
    input  logic [$clog2(MAX_ACCS)-1:0] cmdout_in_tid,
    input  logic [63:0]                 cmdout_in_tdata,
    input  logic                        cmdout_in_tlast,
    output logic                        cmdout_queue_clk,
    output logic                        cmdout_queue_rst,
    output logic                        cmdout_queue_en,
    output logic [7:0]                  cmdout_queue_we,
    output logic [31:0]                 cmdout_queue_addr,
    output logic [63:0]                 cmdout_queue_din,
    input  logic [63:0]                 cmdout_queue_dout,
    output logic                        overflow_err
);

    localparam int TID_W    = $clog2(MAX_ACCS);
    localparam int SLOT_W   = $clog2(SUBQUEUE_LEN);
    localparam int ADDR_PAD = 32 - TID_W - SLOT_W - 3;
    localparam int WAIT_W   = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((RETRY_WAIT > 0) ? RETRY_WAIT - 1 : 0);
    localparam logic [SLOT_W-1:0] CNT_LAST = SLOT_W'(SUBQUEUE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CHK,
        S_WAIT,
        S_PUB,
        S_DROP
    } state_t;

    state_t state, state_nx;

    logic [1:0]        rst_pipe;
    logic              rst_n;
    logic [TID_W-1:0]  cur_tid;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] hdr_slot;
    logic [SLOT_W-1:0] cnt;
    logic              first;
    logic [63:0]       hdr_reg;
    logic [WAIT_W-1:0] wait_cnt;
    logic [SLOT_W-1:0] wptr [MAX_ACCS];

    logic              occupied;
    logic              accept;
    logic              q_en;
    logic [7:0]        q_we;
    logic [31:0]       q_addr;
    logic [63:0]       q_din;
    logic [63:0]       pub_word;
    logic              unused_dout;

    function automatic logic [31:0] addr_of(
        input logic [TID_W-1:0]  t,
        input logic [SLOT_W-1:0] s
    );
        return {{ADDR_PAD{1'b0}}, t, s, 3'b000};
    endfunction

    // Assert asynchronously, release on the clock to avoid metastable exits
    always_ff @(posedge aclk or negedge interconnect_aresetn) begin
        if (!interconnect_aresetn) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    assign occupied    = cmdout_queue_dout[VALID_BIT];
    assign unused_dout = ^cmdout_queue_dout;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        q_en     = 1'b0;
        q_we     = 8'h00;
        q_addr   = 32'h0;
        q_din    = 64'h0;
        pub_word = hdr_reg;
        pub_word[VALID_BIT] = 1'b1;
        cmdout_in_tready = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmdout_in_tvalid) begin
                    state_nx = S_RD;
                end
            end
            S_RD: begin
                q_en     = 1'b1;
                q_addr   = addr_of(cur_tid, slot);
                state_nx = S_CHK;
            end
            S_CHK: begin
                if (occupied) begin
                    state_nx = (RETRY_WAIT == 0) ? S_RD : S_WAIT;
                end else begin
                    cmdout_in_tready = 1'b1;
                    if (cmdout_in_tvalid) begin
                        accept = 1'b1;
                        if (!first) begin
                            q_en   = 1'b1;
                            q_we   = 8'hFF;
                            q_addr = addr_of(cur_tid, slot);
                            q_din  = cmdout_in_tdata;
                        end
                        if (cmdout_in_tlast) begin
                            state_nx = S_PUB;
                        end else if (cnt == CNT_LAST) begin
                            state_nx = S_DROP;
                        end else begin
                            state_nx = S_RD;
                        end
                    end else begin
                        // Read data may be stale by the time the beat shows up
                        state_nx = S_RD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_RD;
                end
            end
            S_PUB: begin
                q_en     = 1'b1;
                q_we     = 8'hFF;
                q_addr   = addr_of(cur_tid, hdr_slot);
                q_din    = pub_word;
                state_nx = S_IDLE;
            end
            S_DROP: begin
                cmdout_in_tready = 1'b1;
                if (cmdout_in_tvalid && cmdout_in_tlast) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_tid      <= '0;
            slot         <= '0;
            hdr_slot     <= '0;
            cnt          <= '0;
            first        <= 1'b0;
            hdr_reg      <= 64'h0;
            wait_cnt     <= '0;
            overflow_err <= 1'b0;
            for (int i = 0; i < MAX_ACCS; i++) begin
                wptr[i] <= '0;
            end
        end else begin
            if (state == S_IDLE && cmdout_in_tvalid) begin
                cur_tid  <= cmdout_in_tid;
                slot     <= wptr[cmdout_in_tid];
                hdr_slot <= wptr[cmdout_in_tid];
                cnt      <= '0;
                first    <= 1'b1;
            end
            if (accept) begin
                if (first) begin
                    hdr_reg <= cmdout_in_tdata;
                end
                slot  <= slot + 1'b1;
                cnt   <= cnt + 1'b1;
                first <= 1'b0;
                if (!cmdout_in_tlast && cnt == CNT_LAST) begin
                    overflow_err <= 1'b1;
                end
            end
            if (state == S_CHK && occupied) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_PUB) begin
                wptr[cur_tid] <= slot;
            end
        end
    end

    assign cmdout_queue_clk  = aclk;
    assign cmdout_queue_rst  = ~interconnect_aresetn;
    assign cmdout_queue_en   = q_en;
    assign cmdout_queue_we   = q_we;
    assign cmdout_queue_addr = q_addr;
    assign cmdout_queue_din  = q_din;

endmodule

// File: doc/cmdout_subqueue_writer.md
Name: cmdout_subqueue_writer

Overview:
- Accepts multi-beat cmdout commands from up to MAX_ACCS accelerators on one AXI-Stream input.
- Stores each command into that accelerator's circular subqueue inside the shared cmdout BRAM.
- Checks each destination slot is free (valid bit clear) before writing to it.
- Publishes a command atomically: payload words are written first and the header word, with its valid bit set, is written last. Software consumes entries and clears the valid bits.

Parameters:
- MAX_ACCS, 16, number of accelerators and of subqueues; tid width is $clog2(MAX_ACCS).
- SUBQUEUE_LEN, 64, words per subqueue; must be a power of two, minimum 4.
- VALID_BIT, 63, bit position of the entry-valid flag in the header word.
- RETRY_WAIT, 4, idle cycles before re-polling an occupied slot; minimum 0.

Ports:
- aclk  in  1  clock.
- interconnect_aresetn  in  1  asynchronous active-low reset.
- cmdout_in_tvalid  in  1  AXI-Stream valid.
- cmdout_in_tready  out  1  AXI-Stream ready.
- cmdout_in_tid  in  $clog2(MAX_ACCS)  source accelerator.
- cmdout_in_tdata  in  64  command word; the first beat is the header.
- cmdout_in_tlast  in  1  last word of the command.
- cmdout_queue_clk  out  1  equals aclk.
- cmdout_queue_rst  out  1  equals ~interconnect_aresetn.
- cmdout_queue_en  out  1  BRAM enable.
- cmdout_queue_we  out  8  byte write enables; 8'hFF on writes, 0 otherwise.
- cmdout_queue_addr  out  32  byte address = (tid*SUBQUEUE_LEN + slot)*8.
- cmdout_queue_din  out  64  write data.
- cmdout_queue_dout  in  64  read data; valid the cycle after a read with en=1, we=0.
- overflow_err  out  1  sticky; set when a command exceeds SUBQUEUE_LEN words.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: tready=0, en=0, we=0, addr=0, din=0, overflow_err=0.
  - State: wptr[0..MAX_ACCS-1]=0; FSM in IDLE; any partial command is discarded. Its header was never written, so software sees nothing.
- Per-accelerator state: wptr[i], $clog2(SUBQUEUE_LEN) bits. Slot arithmetic is modulo SUBQUEUE_LEN, so slot LEN-1 wraps to 0 within the same subqueue.
- IDLE: on tvalid, latch cur_tid=tid, hdr_slot=slot=wptr[tid], first=1, cnt=0. Go to RD. tid must not change until tlast; this rule is not checked.
- RD (1 cycle): en=1, we=0, addr=slot. Go to CHK.
- CHK (1 cycle):
  - If dout[VALID_BIT]=1 (slot occupied): tready=0, go to WAIT.
  - Otherwise (slot free): tready=1 and the beat is consumed this cycle.
    - If first: latch hdr_reg=tdata; no BRAM write.
    - Else: en=1, we=8'hFF, addr=slot, din=tdata.
    - Then slot++, cnt++, first=0.
    - tlast=1 goes to PUB; otherwise go to RD.
  - Oversized command: if cnt reaches SUBQUEUE_LEN before tlast, set overflow_err.
    - Accept and discard the remaining beats with tready=1, one per cycle, without BRAM access.
    - On tlast go to IDLE without publishing; wptr is unchanged.
- WAIT: count RETRY_WAIT cycles, then go to RD. A stalled slot blocks the whole input, with no reordering across tids.
- PUB (1 cycle):
  - en=1, we=8'hFF, addr=hdr_slot, din=hdr_reg with bit VALID_BIT forced to 1.
  - wptr[cur_tid]=slot (one past the last word). Go to IDLE.
- Throughput: 2 cycles per beat with no stall; a command of N beats takes 2N+1 cycles from the first RD to the PUB write, inclusive.
- tready is high only in CHK-accept and discard cycles. tvalid must stay high with data stable until accepted.
- Single BRAM port: read and write never occur in the same cycle.
- Every slot, including the header slot, is checked before use. A subqueue that is full at the header slot stalls before any beat is accepted.
- Single-beat command (tlast on the header): CHK accepts it, PUB writes the header, wptr advances by 1.

Test Plan:
- Basic write: tid=2, 3 beats (0x11, 0x22, 0x33, tlast on the third), BRAM all zero.
  - Writes: addr 0x408 din 0x22, then 0x410 din 0x33, then 0x400 din 0x8000_0000_0000_0011.
  - wptr[2]=3; 7 cycles from the first RD to the header write.
- Stall: preload word 0 of tid=0 with bit63=1; send a 1-beat command to tid=0.
  - tready stays 0 and the slot is re-polled every RETRY_WAIT+2 cycles.
  - Clear bit63 in BRAM: the command is accepted and the header is written at addr 0.
- Wrap-around: wptr[1] preset to 62 by prior traffic; send a 3-beat command to tid=1.
  - Payload goes to slots 63 and 0 (addrs 0x3F8, 0x200); header goes to slot 62 (0x3F0); wptr[1]=1.
- Back-to-back tids: command to tid=5 followed by a command to tid=7, both 2 beats.
  - Each subqueue receives its own words; wptr[5]=2 and wptr[7]=2; no cross-writes.
- Overflow: SUBQUEUE_LEN=4, send a 6-beat command.
  - overflow_err=1; 3 payload writes occur, no header write; beats 5 and 6 are accepted and dropped; wptr is unchanged.
- Reset mid-command: assert interconnect_aresetn=0 after beat 2 of 3.
  - All outputs return to reset values immediately; no header write; after release wptr=0 and a new command writes from slot 0.
